// File: rtl/reg_file_rename.sv
// reg_file_rename: architectural register file with per-register rename
// status (busy bit + producer tag). Serves decoder source lookups, records
// destination allocations and commits results from the write-back bus.
// x0 is hard-wired to zero and is never busy.
// Optional feature: define REG_FILE_BYPASS_EN to forward a same-cycle
// write-back onto the read ports.

module reg_file_rename #(
   parameter int REG_NUM    = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  dec_valid,
   input  logic                  rs1_en,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic                  rs2_en,
   input  logic [ADDR_WIDTH-1:0] rs2,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [TAG_WIDTH-1:0]  dec_tag,
   output logic [DATA_WIDTH-1:0] rs1_data,
   output logic                  rs1_busy,
   output logic [TAG_WIDTH-1:0]  rs1_tag,
   output logic [DATA_WIDTH-1:0] rs2_data,
   output logic                  rs2_busy,
   output logic [TAG_WIDTH-1:0]  rs2_tag,
   input  logic                  wb_en,
   input  logic [TAG_WIDTH-1:0]  wb_tag,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic                  flush,
   output logic [ADDR_WIDTH:0]   busy_count
);

   logic [DATA_WIDTH-1:0] data [REG_NUM];
   logic [TAG_WIDTH-1:0]  tag  [REG_NUM];
   logic [REG_NUM-1:0]    busy;

   logic [REG_NUM-1:0]    wb_match;
   logic [ADDR_WIDTH:0]   match_cnt;
   logic                  alloc;
   logic                  alloc_new;

   // Write-back match vector against pre-edge tags, plus how many registers it frees
   always_comb begin
      wb_match  = '0;
      match_cnt = '0;
      for (int i = 1; i < REG_NUM; i++) begin
         wb_match[i] = wb_en && busy[i] && (tag[i] == wb_tag);
         match_cnt   = match_cnt + (ADDR_WIDTH+1)'(wb_match[i]);
      end
   end

   // Allocation qualification; it only adds to the busy count if rd ends up newly busy
   always_comb begin
      alloc     = dec_valid && rd_en && (rd != '0) && !flush;
      alloc_new = alloc && (!busy[rd] || wb_match[rd]);
   end

   // Register state update: write-back commits data, allocation wins busy/tag, flush clears status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= '0;
         for (int i = 0; i < REG_NUM; i++) begin
            data[i] <= '0;
            tag[i]  <= '0;
         end
      end else begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (wb_match[i]) begin
               data[i] <= wb_data;
            end
            if (flush) begin
               busy[i] <= 1'b0;
               tag[i]  <= '0;
            end else if (alloc && (rd == ADDR_WIDTH'(i))) begin
               busy[i] <= 1'b1;
               tag[i]  <= dec_tag;
            end else if (wb_match[i]) begin
               busy[i] <= 1'b0;
            end
         end
      end
   end

   // Incremental busy counter tracking the popcount of the next-state busy vector
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_count <= '0;
      end else if (flush) begin
         busy_count <= '0;
      end else begin
         busy_count <= busy_count - match_cnt + (ADDR_WIDTH+1)'(alloc_new);
      end
   end

   // Source 1 lookup from current state (optionally forwarding the write-back bus)
   always_comb begin
      rs1_data = '0;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
      if (rs1_en && (rs1 != '0)) begin
         rs1_data = data[rs1];
         rs1_busy = busy[rs1];
         rs1_tag  = tag[rs1];
`ifdef REG_FILE_BYPASS_EN
         if (wb_match[rs1]) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
         end
`endif
      end
   end

   // Source 2 lookup from current state (optionally forwarding the write-back bus)
   always_comb begin
      rs2_data = '0;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
      if (rs2_en && (rs2 != '0)) begin
         rs2_data = data[rs2];
         rs2_busy = busy[rs2];
         rs2_tag  = tag[rs2];
`ifdef REG_FILE_BYPASS_EN
         if (wb_match[rs2]) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_rename.sv
// tb_reg_file_rename: directed self-checking bench for reg_file_rename.
// Expected values are hand-computed constants for each directed vector.

module tb_reg_file_rename;

   logic        clk;
   logic        rst;
   logic        dec_valid;
   logic        rs1_en;
   logic [4:0]  rs1;
   logic        rs2_en;
   logic [4:0]  rs2;
   logic        rd_en;
   logic [4:0]  rd;
   logic [3:0]  dec_tag;
   logic [31:0] rs1_data;
   logic        rs1_busy;
   logic [3:0]  rs1_tag;
   logic [31:0] rs2_data;
   logic        rs2_busy;
   logic [3:0]  rs2_tag;
   logic        wb_en;
   logic [3:0]  wb_tag;
   logic [31:0] wb_data;
   logic        flush;
   logic [5:0]  busy_count;

   int compareCount = 0;
   int failCount    = 0;

   reg_file_rename dut (
      .clk        (clk),
      .rst        (rst),
      .dec_valid  (dec_valid),
      .rs1_en     (rs1_en),
      .rs1        (rs1),
      .rs2_en     (rs2_en),
      .rs2        (rs2),
      .rd_en      (rd_en),
      .rd         (rd),
      .dec_tag    (dec_tag),
      .rs1_data   (rs1_data),
      .rs1_busy   (rs1_busy),
      .rs1_tag    (rs1_tag),
      .rs2_data   (rs2_data),
      .rs2_busy   (rs2_busy),
      .rs2_tag    (rs2_tag),
      .wb_en      (wb_en),
      .wb_tag     (wb_tag),
      .wb_data    (wb_data),
      .flush      (flush),
      .busy_count (busy_count)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Present one decode/write-back/flush vector; takes effect at the next edge
   task automatic applyStimulus(input logic dv, input logic [4:0] rdIdx, input logic [3:0] dTag,
                                input logic wbe, input logic [3:0] wTag, input logic [31:0] wData,
                                input logic fl);
      dec_valid = dv;
      rd_en     = dv;
      rd        = rdIdx;
      dec_tag   = dTag;
      wb_en     = wbe;
      wb_tag    = wTag;
      wb_data   = wData;
      flush     = fl;
   endtask

   // Advance through one rising edge, sample 1 unit later, then idle the controls
   task automatic stepCycle();
      @(posedge clk);
      #1;
      dec_valid = 1'b0;
      rd_en     = 1'b0;
      wb_en     = 1'b0;
      flush     = 1'b0;
      #1;
   endtask

   task automatic readPorts(input logic [4:0] a, input logic [4:0] b);
      rs1_en = 1'b1;
      rs1    = a;
      rs2_en = 1'b1;
      rs2    = b;
      #1;
   endtask

   initial begin
      rst    = 1'b0;
      rs1_en = 1'b0;
      rs1    = '0;
      rs2_en = 1'b0;
      rs2    = '0;
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
      #12;
      readPorts(5'd5, 5'd3);
      checkOutput("reset_rs1_data", rs1_data, 32'h0);
      checkOutput("reset_rs1_busy", 32'(rs1_busy), 32'h0);
      checkOutput("reset_count", 32'(busy_count), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      stepCycle();

      // Allocate x3 tag 7, then commit 0xDEADBEEF
      applyStimulus(1'b1, 5'd3, 4'd7, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      readPorts(5'd3, 5'd0);
      checkOutput("alloc_busy", 32'(rs1_busy), 32'h1);
      checkOutput("alloc_tag", 32'(rs1_tag), 32'h7);
      checkOutput("alloc_count", 32'(busy_count), 32'h1);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd7, 32'hDEADBEEF, 1'b0);
      stepCycle();
      checkOutput("commit_data", rs1_data, 32'hDEADBEEF);
      checkOutput("commit_busy", 32'(rs1_busy), 32'h0);
      checkOutput("commit_count", 32'(busy_count), 32'h0);

      // Source read of rd in its own allocation cycle sees old status
      readPorts(5'd5, 5'd0);
      applyStimulus(1'b1, 5'd5, 4'd4, 1'b0, 4'd0, 32'h0, 1'b0);
      #1;
      checkOutput("order_pre_busy", 32'(rs1_busy), 32'h0);
      stepCycle();
      checkOutput("order_post_busy", 32'(rs1_busy), 32'h1);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd4, 32'h5, 1'b0);
      stepCycle();
      checkOutput("order_commit", rs1_data, 32'h5);
      checkOutput("order_count", 32'(busy_count), 32'h0);

      // Reallocate x4 during its own write-back
      applyStimulus(1'b1, 5'd4, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 5'd4, 4'd9, 1'b1, 4'd2, 32'h11, 1'b0);
      stepCycle();
      readPorts(5'd4, 5'd0);
      checkOutput("realloc_data", rs1_data, 32'h11);
      checkOutput("realloc_busy", 32'(rs1_busy), 32'h1);
      checkOutput("realloc_tag", 32'(rs1_tag), 32'h9);
      checkOutput("realloc_count", 32'(busy_count), 32'h1);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd2, 32'h99, 1'b0);
      stepCycle();
      checkOutput("stale_wb_data", rs1_data, 32'h11);
      checkOutput("stale_wb_busy", 32'(rs1_busy), 32'h1);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd9, 32'h22, 1'b0);
      stepCycle();
      checkOutput("realloc_commit", rs1_data, 32'h22);
      checkOutput("realloc_count0", 32'(busy_count), 32'h0);

      // Fresh allocation with the same tag as a same-edge write-back survives
      applyStimulus(1'b1, 5'd8, 4'd5, 1'b1, 4'd5, 32'h77, 1'b0);
      stepCycle();
      readPorts(5'd8, 5'd0);
      checkOutput("fresh_busy", 32'(rs1_busy), 32'h1);
      checkOutput("fresh_data", rs1_data, 32'h0);
      checkOutput("fresh_count", 32'(busy_count), 32'h1);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd5, 32'h33, 1'b0);
      stepCycle();
      checkOutput("fresh_commit", rs1_data, 32'h33);
      checkOutput("fresh_count0", 32'(busy_count), 32'h0);

      // x0 is never busy or written; disabled port reads zero
      applyStimulus(1'b1, 5'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd0, 32'h55, 1'b0);
      stepCycle();
      readPorts(5'd0, 5'd0);
      checkOutput("x0_data", rs1_data, 32'h0);
      checkOutput("x0_busy", 32'(rs1_busy), 32'h0);
      checkOutput("x0_count", 32'(busy_count), 32'h0);
      rs1_en = 1'b0;
      rs1    = 5'd4;
      #1;
      checkOutput("disabled_read", rs1_data, 32'h0);

      // Flush with same-edge write-back; allocation suppressed
      applyStimulus(1'b1, 5'd2, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd2, 32'hBB, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 5'd1, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 5'd2, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      checkOutput("preflush_count", 32'(busy_count), 32'h2);
      applyStimulus(1'b1, 5'd9, 4'd3, 1'b1, 4'd1, 32'hA, 1'b1);
      stepCycle();
      readPorts(5'd1, 5'd2);
      checkOutput("flush_x1_data", rs1_data, 32'hA);
      checkOutput("flush_x1_busy", 32'(rs1_busy), 32'h0);
      checkOutput("flush_x2_data", rs2_data, 32'hBB);
      checkOutput("flush_x2_busy", 32'(rs2_busy), 32'h0);
      checkOutput("flush_x2_tag", 32'(rs2_tag), 32'h0);
      checkOutput("flush_count", 32'(busy_count), 32'h0);
      readPorts(5'd9, 5'd0);
      checkOutput("flush_alloc_blocked", 32'(rs1_busy), 32'h0);

      // Duplicate tags: one write-back clears both
      applyStimulus(1'b1, 5'd10, 4'd12, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 5'd11, 4'd12, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      checkOutput("dup_count", 32'(busy_count), 32'h2);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd12, 32'hC0DE, 1'b0);
      stepCycle();
      readPorts(5'd10, 5'd11);
      checkOutput("dup_x10", rs1_data, 32'hC0DE);
      checkOutput("dup_x11", rs2_data, 32'hC0DE);
      checkOutput("dup_count0", 32'(busy_count), 32'h0);

      // Same-cycle write-back visibility on the read port
      applyStimulus(1'b1, 5'd6, 4'd3, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      readPorts(5'd0, 5'd6);
      applyStimulus(1'b0, 5'd0, 4'd0, 1'b1, 4'd3, 32'h42, 1'b0);
      #1;
`ifdef REG_FILE_BYPASS_EN
      checkOutput("bypass_data", rs2_data, 32'h42);
      checkOutput("bypass_busy", 32'(rs2_busy), 32'h0);
      checkOutput("bypass_tag", 32'(rs2_tag), 32'h0);
`else
      checkOutput("nobypass_busy", 32'(rs2_busy), 32'h1);
      checkOutput("nobypass_tag", 32'(rs2_tag), 32'h3);
`endif
      stepCycle();
      checkOutput("bypass_after_data", rs2_data, 32'h42);
      checkOutput("bypass_after_busy", 32'(rs2_busy), 32'h0);

      // Asynchronous reset mid-cycle with busy registers
      applyStimulus(1'b1, 5'd12, 4'd1, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      applyStimulus(1'b1, 5'd13, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0);
      stepCycle();
      readPorts(5'd12, 5'd6);
      checkOutput("prereset_count", 32'(busy_count), 32'h2);
      rst = 1'b0;
      #1;
      checkOutput("async_rs1_busy", 32'(rs1_busy), 32'h0);
      checkOutput("async_rs1_tag", 32'(rs1_tag), 32'h0);
      checkOutput("async_rs2_data", rs2_data, 32'h0);
      checkOutput("async_count", 32'(busy_count), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      stepCycle();
      readPorts(5'd5, 5'd0);
      checkOutput("post_reset_data", rs1_data, 32'h0);
      checkOutput("post_reset_busy", 32'(rs1_busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
